// File: rtl/btb_pkg.sv
// btb_pkg: shared BTB types, including the branch update unit's queue entry and FSM states.
package btb_pkg;
   typedef logic [31:0] word_t;
   typedef struct packed {
      word_t pc;
      word_t target;
      logic  taken;
   } btb_update_t;
   typedef enum logic {BRU_IDLE, BRU_RECOVER} bru_state_t;
endpackage

// File: rtl/bru_update_fifo.sv
// bru_update_fifo: small FIFO of BTB training updates; head reads as zero when empty.
module bru_update_fifo
   import btb_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     push,
   input  logic                     pop,
   input  btb_update_t              din,
   output btb_update_t              dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(QDEPTH):0]  count
);
   localparam int AW = $clog2(QDEPTH);
   btb_update_t mem [QDEPTH];
   logic [AW-1:0] wr, rd;
   logic do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(QDEPTH);
   assign do_pop  = pop & ~empty;
   // a full queue still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd];
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr] <= din;
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/branch_update_unit.sv
// branch_update_unit: resolves EX branches, raises flush/redirect on mispredict, queues BTB training writes.
// Optional BRU_PERF_EN adds saturating br_cnt, mispred_cnt and drop_cnt outputs.
module branch_update_unit
   import btb_pkg::*;
#(
   parameter int QDEPTH         = 2,
   parameter int RECOVER_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        en,
   input  logic        res_valid,
   input  logic [31:0] res_pc,
   input  logic        res_pred_taken,
   input  logic [31:0] res_pred_target,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   input  logic        upd_ok,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        WEN,
   output logic [31:0] pc_w,
   output logic [31:0] target_w,
   output logic        taken_w,
   output logic        q_full
`ifdef BRU_PERF_EN
  ,output logic [31:0] br_cnt,
   output logic [31:0] mispred_cnt,
   output logic [31:0] drop_cnt
`endif
);
   localparam int CW = $clog2(RECOVER_CYCLES + 1);
   bru_state_t state, next_state;
   logic [CW-1:0] cnt, cnt_next;
   logic accept, mispredict, empty, full, drop;
   logic [$clog2(QDEPTH):0] count;
   word_t correct_pc;
   btb_update_t head;
   assign accept     = res_valid & en & (state == BRU_IDLE);
   assign mispredict = (res_taken != res_pred_taken) | (res_taken & (res_target != res_pred_target));
   assign correct_pc = res_taken ? res_target : res_pc + 32'd4;
   assign WEN        = ~empty & upd_ok;
   assign drop       = accept & full & ~WEN;
   assign pc_w       = head.pc;
   assign target_w   = head.target;
   assign taken_w    = head.taken;
   assign q_full     = count == ($clog2(QDEPTH)+1)'(QDEPTH);
   bru_update_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (accept),
      .pop   (WEN),
      .din   ('{pc: res_pc, target: res_target, taken: res_taken}),
      .dout  (head),
      .empty (empty),
      .full  (full),
      .count (count)
   );
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      if (state == BRU_IDLE) begin
         if (accept & mispredict) begin
            next_state = BRU_RECOVER;
            cnt_next   = CW'(RECOVER_CYCLES);
         end
      end else if (en) begin
         cnt_next   = cnt - 1'b1;
         next_state = (cnt == CW'(1)) ? BRU_IDLE : BRU_RECOVER;
      end
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= BRU_IDLE;
         cnt         <= '0;
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
         flush <= accept & mispredict;
         if (accept & mispredict) redirect_pc <= correct_pc;
      end
   end
`ifdef BRU_PERF_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         br_cnt      <= '0;
         mispred_cnt <= '0;
         drop_cnt    <= '0;
      end else begin
         if (accept && br_cnt != '1) br_cnt <= br_cnt + 1'b1;
         if (accept && mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
         if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_branch_update_unit.sv
// tb_branch_update_unit: directed resolves with hand-computed BTB writes and redirects checked by a scoreboard monitor.
module tb_branch_update_unit;
   logic        CLK = 0, nRST = 0, en = 1, res_valid = 0, res_pred_taken = 0, res_taken = 0, upd_ok = 1;
   logic [31:0] res_pc = 0, res_pred_target = 0, res_target = 0;
   logic        flush, WEN, taken_w, q_full;
   logic [31:0] redirect_pc, pc_w, target_w;
`ifdef BRU_PERF_EN
   logic [31:0] br_cnt, mispred_cnt, drop_cnt;
`endif
   int checks = 0, errors = 0;
   logic [64:0] exp_wr [$];
   logic [31:0] exp_fl [$];

   branch_update_unit #(.QDEPTH(2), .RECOVER_CYCLES(1)) dut (
      .CLK(CLK), .nRST(nRST), .en(en), .res_valid(res_valid), .res_pc(res_pc),
      .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
      .res_taken(res_taken), .res_target(res_target), .upd_ok(upd_ok),
      .flush(flush), .redirect_pc(redirect_pc), .WEN(WEN), .pc_w(pc_w),
      .target_w(target_w), .taken_w(taken_w), .q_full(q_full)
`ifdef BRU_PERF_EN
     ,.br_cnt(br_cnt), .mispred_cnt(mispred_cnt), .drop_cnt(drop_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // monitor: every WEN pulse and every flush must match the next expected item
   always @(negedge CLK) begin
      if (nRST) begin
         if (WEN) begin
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL btb_write: unexpected pc_w %h", pc_w);
            end else begin
               logic [64:0] e;
               e = exp_wr.pop_front();
               if ({pc_w, target_w, taken_w} !== e) begin
                  errors++;
                  $display("FAIL btb_write: got %h/%h/%b expected %h/%h/%b",
                           pc_w, target_w, taken_w, e[64:33], e[32:1], e[0]);
               end
            end
         end
         if (flush) begin
            checks++;
            if (exp_fl.size() == 0) begin
               errors++;
               $display("FAIL flush: unexpected flush redirect_pc %h", redirect_pc);
            end else begin
               logic [31:0] r;
               r = exp_fl.pop_front();
               if (redirect_pc !== r) begin
                  errors++;
                  $display("FAIL redirect_pc: got %h expected %h", redirect_pc, r);
               end
            end
         end
      end
   end

   // one resolve held across one rising edge; enq/fl/rpc are the hand-derived outcomes
   task automatic res(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                      input logic t, input logic [31:0] tgt,
                      input logic enq, input logic fl, input logic [31:0] rpc);
      res_valid = 1; res_pc = pc; res_pred_taken = pt; res_pred_target = ptgt;
      res_taken = t; res_target = tgt;
      if (enq) exp_wr.push_back({pc, tgt, t});
      if (fl) exp_fl.push_back(rpc);
      @(posedge CLK); #1;
      res_valid = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      #2;
      check("reset_flush", 32'(flush), 0);
      check("reset_redirect", redirect_pc, 0);
      check("reset_wen", 32'(WEN), 0);
      check("reset_pc_w", pc_w, 0);
      check("reset_q_full", 32'(q_full), 0);
      @(posedge CLK); #1 nRST = 1;
      idle(1);
      // correct taken prediction
      res(32'h100, 1, 32'h200, 1, 32'h200, 1, 0, 0);
      idle(3);
      // direction mispredict, wrong-path resolve during recovery, then accepted resolve
      res(32'h40, 1, 32'h0, 0, 32'h0, 1, 1, 32'h44);
      res(32'h50, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      res(32'h60, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      idle(3);
      // target mispredict; en low in recovery holds the counter
      res(32'h70, 1, 32'h300, 1, 32'h380, 1, 1, 32'h380);
      en = 0;
      res(32'h80, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      res(32'h84, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      en = 1;
      res(32'h90, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      res(32'hA0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      idle(3);
      check("redirect_hold", redirect_pc, 32'h380);
      // overflow: third accept dropped
      upd_ok = 0;
      res(32'h10, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      res(32'h20, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      res(32'h30, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      idle(1);
      check("overflow_q_full", 32'(q_full), 1);
      upd_ok = 1;
      idle(4);
      @(negedge CLK);
      check("drained_wen", 32'(WEN), 0);
      check("drained_q_full", 32'(q_full), 0);
      // full with simultaneous pop and push
      upd_ok = 0;
      idle(1);
      res(32'h11, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      res(32'h22, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      check("pre_swap_q_full", 32'(q_full), 1);
      upd_ok = 1;
      res(32'h33, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      check("swap_q_full", 32'(q_full), 1);
      idle(4);
`ifdef BRU_PERF_EN
      check("br_cnt", br_cnt, 11);
      check("mispred_cnt", mispred_cnt, 2);
      check("drop_cnt", drop_cnt, 1);
`endif
      // async reset during recovery with two queued updates
      upd_ok = 0;
      res(32'h400, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      res(32'h500, 0, 32'h0, 1, 32'h600, 1, 1, 32'h600);
      check("pre_reset_flush", 32'(flush), 1);
      #2;
      nRST = 0; upd_ok = 1;
      exp_wr.delete(); exp_fl.delete();
      #1;
      check("areset_flush", 32'(flush), 0);
      check("areset_wen", 32'(WEN), 0);
      check("areset_redirect", redirect_pc, 0);
      check("areset_q_full", 32'(q_full), 0);
`ifdef BRU_PERF_EN
      check("areset_br_cnt", br_cnt, 0);
`endif
      idle(2);
      #3 nRST = 1;
      idle(3);
      @(negedge CLK);
      check("post_reset_wen", 32'(WEN), 0);
      @(posedge CLK); #1;
      res(32'h700, 0, 32'h0, 0, 32'h0, 1, 0, 0);
      idle(3);
      check("sb_writes_left", exp_wr.size(), 0);
      check("sb_flushes_left", exp_fl.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
